// File: rtl/pipeline_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_adder_pkg
//   Shared defaults and types for the 4-stage pipelined adder and its
//   downstream result buffer.
//   Contents:
//     WIDTH_DEF / STAGES_DEF / DEPTH_DEF / AFULL_DEF : default parameters
//     result_t      : packed {cout, sum} record as it sits in the FIFO
//     result_width  : bit width of a {cout, sum} record for a given sum width
// ---------------------------------------------------------------------------
package pipeline_adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int AFULL_DEF  = 4;

    typedef struct packed {
        logic                 cout;
        logic [WIDTH_DEF-1:0] sum;
    } result_t;

    localparam int RESULT_W_DEF = $bits(result_t);

    // Carry bit sits on top of the sum.
    function automatic int result_width(input int sum_width);
        return sum_width + 1;
    endfunction

endpackage

// File: rtl/pipeline_adder_result_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO holding {cout, sum} results.
//   The head entry is kept in a dedicated register so the read data is
//   registered and simply holds its last value once the FIFO drains.
//   Ports:
//     i_clk, i_rst   : clock, synchronous active-high reset
//     i_push/i_wdata : write request and data
//     i_pop          : consume head (ignored when empty)
//     o_rdata        : head entry (registered)
//     o_empty        : no entries held
//     o_count        : occupied entries, 0..DEPTH
//     o_count_next   : occupancy after the current edge
//     o_drop         : push refused this cycle because the FIFO is full
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_next,
    output logic          o_drop
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop frees a slot before the push lands, so push is legal when full
    // as long as a pop happens on the same edge.
    assign w_push  = i_push && (!w_full || w_pop);

    assign w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            // Reload the head only when something will be there. The write
            // pointer can only equal the new read pointer while the FIFO is
            // (effectively) empty, in which case the pushed word is the head.
            if (w_count_next != '0) begin
                r_head <= (w_push && (r_wr_ptr == w_rd_next)) ? i_wdata
                                                              : r_mem[w_rd_next];
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata      = r_head;
    assign o_empty      = w_empty;
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_drop       = i_push && w_full && !w_pop;

endmodule

// File: rtl/pipeline_adder_result_buffer.sv
// ---------------------------------------------------------------------------
// pipeline_adder_result_buffer
//   Downstream stage of the stallable pipelined adder. A shadow valid bit per
//   adder stage follows the same stop/flush vectors as the adder; when a live
//   operation leaves the last stage its {cout, sum} is queued in a FIFO and
//   offered on a valid/ready output.
//
//   Handshake: a result transfers on every rising edge where out_valid and
//   out_ready are both high; out_valid never depends on out_ready.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     in_valid   : operation presented to adder stage 0
//     stop       : per-stage hold (same vector as the adder)
//     flush      : per-stage clear (same vector as the adder)
//     sum, cout  : adder last-stage result
//     out_valid  : FIFO head holds a result
//     out_ready  : consumer accepts the head
//     out_sum    : head sum
//     out_cout   : head carry
//     stall_req  : registered backpressure towards the issuer/adder
//     count      : occupied FIFO entries
//     overflow   : sticky, a retiring result was dropped
// ---------------------------------------------------------------------------
module pipeline_adder_result_buffer
    import pipeline_adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AFULL  = AFULL_DEF,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int RW    = result_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [STAGES-1:0] stop,
    input  logic [STAGES-1:0] flush,
    input  logic [WIDTH-1:0]  sum,
    input  logic              cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_cout,
    output logic              stall_req,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    logic [STAGES-1:0] r_vq;
    logic              r_stall_req;
    logic              r_overflow;

    logic [STAGES-1:0] w_vq_next;
    logic              w_retire;
    logic [RW-1:0]     w_head;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic              w_drop;
    logic [CW:0]       w_free_next;

    // Shadow valid pipeline, priority flush > stop > advance. When stage k-1
    // is held, stage k receives a bubble so a held op is never duplicated.
    always_comb begin
        w_vq_next = r_vq;
        if (flush[0]) begin
            w_vq_next[0] = 1'b0;
        end else if (stop[0]) begin
            w_vq_next[0] = r_vq[0];
        end else begin
            w_vq_next[0] = in_valid;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (flush[k]) begin
                w_vq_next[k] = 1'b0;
            end else if (stop[k]) begin
                w_vq_next[k] = r_vq[k];
            end else begin
                w_vq_next[k] = stop[k-1] ? 1'b0 : r_vq[k-1];
            end
        end
    end

    // A live op leaves the last stage only on an edge where that stage is
    // neither held nor cleared; a held op therefore retires exactly once.
    assign w_retire = r_vq[STAGES-1] && !stop[STAGES-1] && !flush[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vq <= '0;
        end else begin
            r_vq <= w_vq_next;
        end
    end

    sync_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_push       (w_retire),
        .i_wdata      ({cout, sum}),
        .i_pop        (out_ready),
        .o_rdata      (w_head),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_drop       (w_drop)
    );

    // Free slots after this edge; one extra bit keeps the subtraction clean.
    assign w_free_next = (CW+1)'(DEPTH) - {1'b0, w_count_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_req <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_stall_req <= (w_free_next <= (CW+1)'(AFULL));
            r_overflow  <= r_overflow | w_drop;
        end
    end

    assign out_valid = !w_empty;
    assign out_sum   = w_head[WIDTH-1:0];
    assign out_cout  = w_head[WIDTH];
    assign stall_req = r_stall_req;
    assign count     = w_count;
    assign overflow  = r_overflow;

endmodule
